serial_mem_bridge: RTL and testbench

- Parametrised serial memory bridge between the jrb8 core and the off-chip ROM/RAM host link.
- Replaces the ad-hoc per-memory serial counters with one FSM clocked on sclk and gated by ready.
- Supports ROM read, RAM read and RAM write with configurable address/data widths, an opcode header, and a done/busy handshake towards the core.

---
 rtl/serial_mem_bridge.sv | 250 +++++++++++++++++++++++++
 tb/tb_serial_mem_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_mem_bridge.sv
// Serial memory bridge: one FSM shifts opcode, address and write data MSB-first
// to the host and assembles read words from serial_in.
// Latency: ROM read 2+ADDR_W+DATA_W beats, RAM ops 2+RAM_ADDR_W+DATA_W beats.
// Backpressure: ready=0 freezes the transfer; accept and the DONE exit ignore ready.
module serial_mem_bridge #(
    parameter int ADDR_W     = 16,
    parameter int RAM_ADDR_W = 8,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 6
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              ready,
    input  logic              serial_in,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              serial_out,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_out_flag,
    output logic              ram_out_flag,
    output logic              ram_in_flag,
    output logic              addr_phase
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPC   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ROM   = 2'b00;
    localparam logic [1:0] OP_RAMRD = 2'b01;
    localparam logic [1:0] OP_RAMWR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // RAM addresses are left-aligned in the address shifter so that the MSB
    // of whichever address is being sent always sits at bit ADDR_W-1.
    localparam int RAM_SHIFT = ADDR_W - RAM_ADDR_W;

    localparam logic [CNT_W-1:0] ROM_ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] RAM_ADDR_LAST = CNT_W'(RAM_ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST     = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]   wd_sh_q, wd_sh_d;
    logic [DATA_W-1:0]   rd_sh_q, rd_sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                so_q, so_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                addr_last;
    logic                data_last;
    logic                is_write;
    logic [DATA_W-1:0]   rd_word;

    assign addr_last = (cnt_q == ((op_q == OP_ROM) ? ROM_ADDR_LAST : RAM_ADDR_LAST));
    assign data_last = (cnt_q == DATA_LAST);
    assign is_write  = (op_q == OP_RAMWR);
    assign rd_word   = {rd_sh_q[DATA_W-2:0], serial_in};

    // State register: async reset aborts any transfer straight back to IDLE.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transfer phase advances only on ready beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && (op != OP_RSVD)) begin
                    state_d = S_OPC;
                end
            end
            S_OPC: begin
                if (ready && (cnt_q != '0)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ready && addr_last) begin
                    state_d = is_write ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                if (ready && data_last) begin
                    state_d = S_DONE;
                end
            end
            S_RDATA: begin
                if (ready && data_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath logic: each beat presents the next bit and shifts the
    // matching register; done and err are single-cycle pulses by default.
    always_comb begin
        op_d      = op_q;
        addr_sh_d = addr_sh_q;
        wd_sh_d   = wd_sh_q;
        rd_sh_d   = rd_sh_q;
        cnt_d     = cnt_q;
        so_d      = so_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (op == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_d      = op;
                        addr_sh_d = (op == OP_ROM) ? addr : (addr << RAM_SHIFT);
                        wd_sh_d   = wdata;
                        rd_sh_d   = '0;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        so_d      = op[1];
                    end
                end
            end
            S_OPC: begin
                if (ready) begin
                    if (cnt_q == '0) begin
                        so_d  = op_q[0];
                        cnt_d = CNT_W'(1);
                    end else begin
                        so_d      = addr_sh_q[ADDR_W-1];
                        addr_sh_d = addr_sh_q << 1;
                        cnt_d     = '0;
                    end
                end
            end
            S_ADDR: begin
                if (ready) begin
                    if (addr_last) begin
                        cnt_d = '0;
                        if (is_write) begin
                            so_d    = wd_sh_q[DATA_W-1];
                            wd_sh_d = wd_sh_q << 1;
                        end else begin
                            so_d = 1'b0;
                        end
                    end else begin
                        so_d      = addr_sh_q[ADDR_W-1];
                        addr_sh_d = addr_sh_q << 1;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WDATA: begin
                if (ready) begin
                    if (data_last) begin
                        so_d   = 1'b0;
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        so_d    = wd_sh_q[DATA_W-1];
                        wd_sh_d = wd_sh_q << 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RDATA: begin
                if (ready) begin
                    rd_sh_d = rd_word;
                    if (data_last) begin
                        rdata_d = rd_word;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath registers: cleared by async reset so an aborted transfer leaves no residue.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            addr_sh_q <= '0;
            wd_sh_q   <= '0;
            rd_sh_q   <= '0;
            cnt_q     <= '0;
            so_q      <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            op_q      <= op_d;
            addr_sh_q <= addr_sh_d;
            wd_sh_q   <= wd_sh_d;
            rd_sh_q   <= rd_sh_d;
            cnt_q     <= cnt_d;
            so_q      <= so_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign serial_out   = so_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rom_out_flag = busy_q & (op_q == OP_ROM);
    assign ram_out_flag = busy_q & (op_q == OP_RAMRD);
    assign ram_in_flag  = busy_q & (op_q == OP_RAMWR);
    assign addr_phase   = (state_q == S_ADDR);

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge: ROM/RAM transfers, stalls, reset abort,
// reserved opcode, latched inputs and back-to-back requests.
// Outputs are sampled 1 time unit after each rising sclk edge.
module tb_serial_mem_bridge;

    logic        sclk = 1'b0;
    logic        rst;
    logic        ready;
    logic        serial_in;
    logic        req;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        serial_out;
    logic [7:0]  rdata;
    logic        busy, done, err;
    logic        rom_out_flag, ram_out_flag, ram_in_flag, addr_phase;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [7:0] model_rdata;

    serial_mem_bridge #(
        .ADDR_W(16), .RAM_ADDR_W(8), .DATA_W(8), .CNT_W(6)
    ) dut (
        .sclk(sclk), .rst(rst), .ready(ready), .serial_in(serial_in),
        .req(req), .op(op), .addr(addr), .wdata(wdata),
        .serial_out(serial_out), .rdata(rdata), .busy(busy), .done(done),
        .err(err), .rom_out_flag(rom_out_flag), .ram_out_flag(ram_out_flag),
        .ram_in_flag(ram_in_flag), .addr_phase(addr_phase)
    );

    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: accept, every beat, and the DONE edge.
    // stall: ready low on every other edge (including the accept edge).
    // hold: req stays high through the transfer and afterwards.
    // scramble: inputs change to junk right after accept.
    task automatic xfer(input logic [1:0] o, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] hw, input bit stall, input bit hold,
                        input bit scramble, input string tag);
        int   aw;
        int   nb;
        int   ap_cnt;
        bit   wr;
        logic exp_so [0:63];
        logic [5:0] exp_st;
        aw = (o == 2'b00) ? 16 : 8;
        nb = 2 + aw + 8;
        wr = (o == 2'b10);
        for (int k = 0; k <= nb; k++) begin
            if (k == 0)           exp_so[k] = o[1];
            else if (k == 1)      exp_so[k] = o[0];
            else if (k <= aw + 1) exp_so[k] = a[aw - 1 - (k - 2)];
            else if (wr && k < nb) exp_so[k] = wd[7 - (k - aw - 2)];
            else                  exp_so[k] = 1'b0;
        end
        req = 1'b1; op = o; addr = a; wdata = wd; serial_in = 1'b0;
        ready = stall ? 1'b0 : 1'b1;
        tick();
        chk({tag, "_accept_so"}, serial_out, exp_so[0]);
        chk({tag, "_accept_busy"}, busy, 1'b1);
        if (scramble) begin
            op = 2'b11; addr = 16'hFFFF; wdata = 8'hFF;
        end
        if (!hold && !scramble) req = 1'b0;
        ap_cnt = 0;
        for (int k = 1; k <= nb; k++) begin
            if (stall) begin
                ready = 1'b0;
                serial_in = ~((k >= aw + 3) ? hw[nb - k] : 1'b0);
                tick();
                chk({tag, "_stall_so"}, serial_out, exp_so[k-1]);
                chk({tag, "_stall_done"}, done, 1'b0);
                ap_cnt += addr_phase;
            end
            ready = 1'b1;
            serial_in = (k >= aw + 3) ? hw[nb - k] : 1'b0;
            tick();
            exp_st = {1'b1, (k == nb), 1'b0, (o == 2'b00), (o == 2'b01), (o == 2'b10)};
            chk({tag, "_so"}, serial_out, exp_so[k]);
            chk({tag, "_status"}, {busy, done, err, rom_out_flag, ram_out_flag, ram_in_flag}, exp_st);
            if (k < nb) chk({tag, "_rdata_hold"}, rdata, model_rdata);
            if (k < nb || stall) ap_cnt += addr_phase;
        end
        chk({tag, "_addr_beats"}, ap_cnt, stall ? 2 * aw : aw);
        if (!wr) model_rdata = hw;
        chk({tag, "_rdata"}, rdata, model_rdata);
        if (!hold) req = 1'b0;
        if (stall) ready = 1'b0;
        tick();
        chk({tag, "_end_busy_done"}, {busy, done}, 2'b00);
        chk({tag, "_end_flags"}, {rom_out_flag, ram_out_flag, ram_in_flag, addr_phase}, 4'b0);
        ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; serial_in = 1'b0; req = 1'b0;
        op = 2'b00; addr = 16'h0; wdata = 8'h0;
        model_rdata = 8'h00;
        tick();
        tick();
        chk("reset_outputs", {serial_out, rdata, busy, done, err, rom_out_flag,
                              ram_out_flag, ram_in_flag, addr_phase}, 16'h0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", {serial_out, rdata, busy, done, err, rom_out_flag,
                             ram_out_flag, ram_in_flag, addr_phase}, 16'h0);

        xfer(2'b00, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, "rom_rd");
        xfer(2'b10, 16'h007F, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, "ram_wr");
        xfer(2'b01, 16'h0005, 8'h00, 8'h81, 1'b1, 1'b0, 1'b0, "ram_rd_stall");

        // Reserved opcode: one-cycle err, no transfer.
        req = 1'b1; op = 2'b11; addr = 16'h0;
        tick();
        chk("rsvd_err_busy", {err, busy}, 2'b10);
        req = 1'b0;
        tick();
        chk("rsvd_err_clear", {err, busy}, 2'b00);

        // Inputs changed mid-transfer with req high must not disturb it.
        xfer(2'b10, 16'h0042, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1, "latched_wr");

        // Reset at beat 10 of a ROM read.
        req = 1'b1; op = 2'b00; addr = 16'hBEEF; ready = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {serial_out, rdata, busy, done, err, rom_out_flag,
                                  ram_out_flag, ram_in_flag, addr_phase}, 16'h0);
        model_rdata = 8'h00;
        tick();
        chk("rst_no_done", {done, busy}, 2'b00);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {done, busy, serial_out}, 3'b000);
        xfer(2'b01, 16'h0033, 8'h00, 8'hC6, 1'b0, 1'b0, 1'b0, "ram_rd_after_rst");

        // Back-to-back ROM reads with req held high.
        xfer(2'b00, 16'h8001, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, "b2b_first");
        xfer(2'b00, 16'h00FF, 8'h00, 8'hE7, 1'b0, 1'b0, 1'b0, "b2b_second");

        tick();
        chk("final_idle", {busy, done, err}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
